// File: rtl/port_latency_ctrl_if.sv
// Request, RAM-side and status signals of one port_latency_ctrl instance.
// Requests are a plain valid strobe: i_en=1 presents one command for exactly that
// cycle, with no ready and no backpressure. o_dout_valid=1 marks one read result
// for exactly that cycle. The RAM side uses the same single-cycle strobe rule.
interface port_latency_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 1
);
  logic                  i_en;
  logic                  i_we;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_din;
  logic                  o_en_wr;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr_wr;
  logic [DATA_WIDTH-1:0] o_din;
  logic                  o_en_rd;
  logic                  o_rd;
  logic [ADDR_WIDTH-1:0] o_addr_rd;
  logic [DATA_WIDTH-1:0] i_mem_dout;
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  o_dout_valid;
  logic [CNT_WIDTH-1:0]  o_wr_pending;
  logic                  o_raw_hazard;

  modport slave (
    input  i_en, i_we, i_addr, i_din, i_mem_dout,
    output o_en_wr, o_we, o_addr_wr, o_din, o_en_rd, o_rd, o_addr_rd,
           o_dout, o_dout_valid, o_wr_pending, o_raw_hazard
  );

  modport master (
    output i_en, i_we, i_addr, i_din, i_mem_dout,
    input  o_en_wr, o_we, o_addr_wr, o_din, o_en_rd, o_rd, o_addr_rd,
           o_dout, o_dout_valid, o_wr_pending, o_raw_hazard
  );
endinterface

// File: rtl/port_latency_ctrl.sv
// Per-port latency stage in front of a dual-port RAM: delays writes, realigns
// read data to a fixed latency and flags reads that hit an in-flight write.
module port_latency_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int WR_LATENCY = 1,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = $clog2(WR_LATENCY + 1)
) (
  input logic clk,
  input logic rst_n,
  port_latency_ctrl_if.slave bus
);

  assign bus.o_en_rd   = bus.i_en;
  assign bus.o_rd      = bus.i_we;
  assign bus.o_addr_rd = bus.i_addr;

  generate
    if (WR_LATENCY == 1) begin : g_wr_comb
      assign bus.o_en_wr      = bus.i_en && bus.i_we;
      assign bus.o_we         = bus.i_en && bus.i_we;
      assign bus.o_addr_wr    = bus.i_addr;
      assign bus.o_din        = bus.i_din;
      assign bus.o_wr_pending = '0;
      assign bus.o_raw_hazard = 1'b0;
    end else begin : g_wr_pipe
      localparam int WS = WR_LATENCY - 1;

      logic [WS-1:0]         vld_q;
      logic [ADDR_WIDTH-1:0] addr_q [WS];
      logic [DATA_WIDTH-1:0] data_q [WS];
      logic [CNT_WIDTH-1:0]  cnt_q;
      logic                  wr_in;
      logic                  wr_out;
      logic                  hit;

      assign wr_in  = bus.i_en && bus.i_we;
      assign wr_out = vld_q[WS-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < WS; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
          end
        end else begin
          vld_q[0]  <= wr_in;
          addr_q[0] <= bus.i_addr;
          data_q[0] <= bus.i_din;
          for (int i = 1; i < WS; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
            data_q[i] <= data_q[i-1];
          end
        end
      end

      // Counts set stage valids: a write enters stage 0 and leaves from the last stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          case ({wr_in, wr_out})
            2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
      end

      always_comb begin
        hit = 1'b0;
        for (int i = 0; i < WS; i++) begin
          if (vld_q[i] && (addr_q[i] == bus.i_addr)) hit = 1'b1;
        end
      end

      assign bus.o_en_wr      = wr_out;
      assign bus.o_we         = wr_out;
      assign bus.o_addr_wr    = addr_q[WS-1];
      assign bus.o_din        = data_q[WS-1];
      assign bus.o_wr_pending = cnt_q;
      assign bus.o_raw_hazard = bus.i_en && !bus.i_we && hit;
    end
  endgenerate

  // Marks the cycle in which the RAM presents data for a read issued one cycle earlier.
  logic rd_iss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_iss_q <= 1'b0;
    else        rd_iss_q <= bus.i_en && !bus.i_we;
  end

  generate
    if (RD_LATENCY == 1) begin : g_rd_direct
      assign bus.o_dout       = bus.i_mem_dout;
      assign bus.o_dout_valid = rd_iss_q;
    end else begin : g_rd_pipe
      localparam int RS = RD_LATENCY - 1;

      logic [RS-1:0]         rvld_q;
      logic [DATA_WIDTH-1:0] rdata_q [RS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvld_q <= '0;
          for (int i = 0; i < RS; i++) rdata_q[i] <= '0;
        end else begin
          rvld_q[0] <= rd_iss_q;
          if (rd_iss_q) rdata_q[0] <= bus.i_mem_dout;
          for (int i = 1; i < RS; i++) begin
            rvld_q[i] <= rvld_q[i-1];
            if (rvld_q[i-1]) rdata_q[i] <= rdata_q[i-1];
          end
        end
      end

      assign bus.o_dout       = rdata_q[RS-1];
      assign bus.o_dout_valid = rvld_q[RS-1];
    end
  endgenerate

endmodule
